// File: rtl/neuron_lif_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons with binary (+1/-1) synapse weights.
// A two-stage datapath computes one neuron per cycle and writes its new state back one cycle later.
module neuron_lif_array #(
  parameter int SYNAPSES        = 32,
  parameter int NEURONS         = 4,
  parameter int MEMBRANE_BITS   = $clog2(SYNAPSES) + 2,
  parameter int THRESHOLD_BITS  = MEMBRANE_BITS - 1,
  parameter int REFRACTORY_BITS = 3,
  localparam int IDX_BITS       = $clog2(NEURONS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [SYNAPSES-1:0]              inputs,
  input  logic                             w_we,
  input  logic [IDX_BITS-1:0]              w_addr,
  input  logic [SYNAPSES-1:0]              w_data,
  input  logic [2:0]                       shift,
  input  logic [THRESHOLD_BITS-1:0]        threshold,
  input  logic [REFRACTORY_BITS-1:0]       refractory,
  output logic                             busy,
  output logic                             done,
  output logic [NEURONS-1:0]               spikes,
  input  logic [IDX_BITS-1:0]              mem_rd_addr,
  output logic signed [MEMBRANE_BITS-1:0]  mem_rd_data
);

  localparam int PSP_BITS = $clog2(SYNAPSES) + 2;
  localparam int W0       = (MEMBRANE_BITS > PSP_BITS) ? MEMBRANE_BITS : PSP_BITS;
  localparam int W1       = (W0 > THRESHOLD_BITS + 1) ? W0 : THRESHOLD_BITS + 1;
  localparam int WIDE     = W1 + 1;
  localparam logic signed [WIDE-1:0] MEM_MAX = WIDE'((2 ** (MEMBRANE_BITS - 1)) - 1);
  localparam logic signed [WIDE-1:0] MEM_MIN = WIDE'(-(2 ** (MEMBRANE_BITS - 1)));

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t r_state, w_state_next;

  logic [SYNAPSES-1:0]             r_weights [NEURONS];
  logic signed [MEMBRANE_BITS-1:0] r_mem     [NEURONS];
  logic [REFRACTORY_BITS-1:0]      r_ref_cnt [NEURONS];

  logic [IDX_BITS-1:0]             r_idx;
  logic                            r_issuing;
  logic [SYNAPSES-1:0]             r_inputs;
  logic [2:0]                      r_shift;
  logic [THRESHOLD_BITS-1:0]       r_threshold;
  logic [REFRACTORY_BITS-1:0]      r_refr;

  logic                            r_wb_valid;
  logic [IDX_BITS-1:0]             r_wb_idx;
  logic signed [MEMBRANE_BITS-1:0] r_wb_mem;
  logic [REFRACTORY_BITS-1:0]      r_wb_ref;
  logic                            r_wb_spike;
  logic [NEURONS-1:0]              r_shadow;
  logic [NEURONS-1:0]              r_spikes;

  logic [SYNAPSES-1:0]             w_row;
  logic signed [1:0]               w_contrib [SYNAPSES];
  logic signed [WIDE-1:0]          w_psp;
  logic signed [MEMBRANE_BITS-1:0] w_u;
  logic signed [MEMBRANE_BITS-1:0] w_d;
  logic signed [WIDE-1:0]          w_d_ext;
  logic signed [WIDE-1:0]          w_acc;
  logic signed [WIDE-1:0]          w_sat;
  logic signed [WIDE-1:0]          w_th_ext;
  logic signed [WIDE-1:0]          w_new_mem_wide;
  logic [REFRACTORY_BITS-1:0]      w_new_ref;
  logic                            w_in_refr;
  logic                            w_fire;
  logic                            w_finish;
  logic [NEURONS-1:0]              w_shadow_next;

  assign w_row = r_weights[r_idx];

  generate
    for (genvar gi = 0; gi < SYNAPSES; gi++) begin : g_syn
      assign w_contrib[gi] = r_inputs[gi] ? (w_row[gi] ? 2'sd1 : -2'sd1) : 2'sd0;
    end
  endgenerate

  always_comb begin
    w_psp = '0;
    for (int i = 0; i < SYNAPSES; i++) begin
      w_psp = w_psp + {{(WIDE-2){w_contrib[i][1]}}, w_contrib[i]};
    end
  end

  // shift=0 would otherwise compute u - u = 0, so it bypasses the leak entirely
  assign w_u       = r_mem[r_idx];
  assign w_d       = (r_shift == 3'd0) ? w_u : w_u - (w_u >>> r_shift);
  assign w_d_ext   = {{(WIDE-MEMBRANE_BITS){w_d[MEMBRANE_BITS-1]}}, w_d};
  assign w_acc     = w_d_ext + w_psp;
  assign w_th_ext  = {{(WIDE-THRESHOLD_BITS){1'b0}}, r_threshold};
  assign w_in_refr = (r_ref_cnt[r_idx] != '0);

  always_comb begin
    w_sat = w_acc;
    if (w_acc > MEM_MAX) w_sat = MEM_MAX;
    else if (w_acc < MEM_MIN) w_sat = MEM_MIN;
  end

  always_comb begin
    w_fire         = 1'b0;
    w_new_mem_wide = w_sat;
    w_new_ref      = '0;
    if (w_in_refr) begin
      w_new_mem_wide = w_d_ext;
      w_new_ref      = r_ref_cnt[r_idx] - REFRACTORY_BITS'(1);
    end else if (w_sat >= w_th_ext) begin
      w_fire         = 1'b1;
      w_new_mem_wide = w_sat - w_th_ext;
      w_new_ref      = r_refr;
    end
  end

  assign w_finish      = (r_state == S_EVAL) && !r_issuing;
  assign w_shadow_next = r_shadow | (r_wb_valid ? (NEURONS'(r_wb_spike) << r_wb_idx) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_EVAL;
      S_EVAL:  if (w_finish) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_issuing   <= 1'b0;
      r_inputs    <= '0;
      r_shift     <= '0;
      r_threshold <= '0;
      r_refr      <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_idx    <= '0;
      r_wb_mem    <= '0;
      r_wb_ref    <= '0;
      r_wb_spike  <= 1'b0;
      r_shadow    <= '0;
      r_spikes    <= '0;
      for (int n = 0; n < NEURONS; n++) begin
        r_weights[n] <= '0;
        r_mem[n]     <= '0;
        r_ref_cnt[n] <= '0;
      end
    end else begin
      r_wb_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_we) r_weights[w_addr] <= w_data;
        if (start) begin
          r_inputs    <= inputs;
          r_shift     <= shift;
          r_threshold <= threshold;
          r_refr      <= refractory;
          r_idx       <= '0;
          r_issuing   <= 1'b1;
          r_shadow    <= '0;
        end
      end
      if ((r_state == S_EVAL) && r_issuing) begin
        r_wb_valid <= 1'b1;
        r_wb_idx   <= r_idx;
        r_wb_mem   <= w_new_mem_wide[MEMBRANE_BITS-1:0];
        r_wb_ref   <= w_new_ref;
        r_wb_spike <= w_fire;
        r_idx      <= r_idx + IDX_BITS'(1);
        if (r_idx == IDX_BITS'(NEURONS - 1)) r_issuing <= 1'b0;
      end
      // the drain cycle's writeback and the spike publish share one edge
      if (r_wb_valid) begin
        r_mem[r_wb_idx]     <= r_wb_mem;
        r_ref_cnt[r_wb_idx] <= r_wb_ref;
        r_shadow            <= w_shadow_next;
      end
      if (w_finish) r_spikes <= w_shadow_next;
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign spikes      = r_spikes;
  assign mem_rd_data = r_mem[mem_rd_addr];

endmodule

// File: tb/tb_neuron_lif_array.sv
// Randomised and directed bench for neuron_lif_array against an arithmetic neuron model.
module tb_neuron_lif_array;

  localparam int SYN = 8;
  localparam int NEU = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [SYN-1:0]    inputs;
  logic              w_we;
  logic [1:0]        w_addr;
  logic [SYN-1:0]    w_data;
  logic [2:0]        shift;
  logic [3:0]        threshold;
  logic [2:0]        refractory;
  logic              busy;
  logic              done;
  logic [NEU-1:0]    spikes;
  logic [1:0]        mem_rd_addr;
  logic signed [4:0] mem_rd_data;

  neuron_lif_array #(
    .SYNAPSES(SYN), .NEURONS(NEU), .MEMBRANE_BITS(5), .THRESHOLD_BITS(4), .REFRACTORY_BITS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inputs(inputs),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .shift(shift), .threshold(threshold), .refractory(refractory),
    .busy(busy), .done(done), .spikes(spikes),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  int n_vectors = 0;
  int n_miscompares = 0;
  int step_no = 0;

  logic [SYN-1:0] m_w [NEU];
  int             m_mem [NEU];
  int             m_ref [NEU];
  logic [NEU-1:0] m_spikes;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int floor_div_pow2(input int u, input int s);
    int p, q;
    p = 1 << s;
    q = u / p;
    if (u < 0 && (q * p) != u) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NEU; n++) begin
      m_w[n] = '0; m_mem[n] = 0; m_ref[n] = 0;
    end
    m_spikes = '0;
  endtask

  task automatic model_step(input logic [SYN-1:0] x, input int sh, input int th, input int rf);
    int psp, d, acc;
    m_spikes = '0;
    for (int n = 0; n < NEU; n++) begin
      d = (sh == 0) ? m_mem[n] : m_mem[n] - floor_div_pow2(m_mem[n], sh);
      if (m_ref[n] > 0) begin
        m_mem[n] = d;
        m_ref[n] = m_ref[n] - 1;
      end else begin
        psp = 0;
        for (int i = 0; i < SYN; i++) if (x[i]) psp += m_w[n][i] ? 1 : -1;
        acc = d + psp;
        if (acc > 15) acc = 15;
        if (acc < -16) acc = -16;
        if (acc >= th) begin
          m_spikes[n] = 1'b1;
          m_mem[n] = acc - th;
          m_ref[n] = rf;
        end else begin
          m_mem[n] = acc;
        end
      end
    end
  endtask

  task automatic read_mem(input int a, output int v);
    mem_rd_addr = 2'(a);
    #1;
    v = int'(mem_rd_data);
  endtask

  task automatic write_w(input int a, input logic [SYN-1:0] d);
    @(negedge clk);
    w_we = 1'b1; w_addr = 2'(a); w_data = d;
    @(negedge clk);
    w_we = 1'b0;
    m_w[a] = d;
    $display("write n%0d weights=%h", a, d);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_spikes", int'(spikes), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_step(input logic [SYN-1:0] x, input int sh, input int th, input int rf,
                          input bit wr, input int wa, input logic [SYN-1:0] wd, input bit disturb);
    int cyc, v;
    @(negedge clk);
    inputs = x; shift = 3'(sh); threshold = 4'(th); refractory = 3'(rf); start = 1'b1;
    if (wr) begin
      w_we = 1'b1; w_addr = 2'(wa); w_data = wd; m_w[wa] = wd;
    end
    model_step(x, sh, th, rf);
    @(negedge clk);
    start = 1'b0; w_we = 1'b0;
    inputs = SYN'($urandom); shift = 3'($urandom); threshold = 4'($urandom); refractory = 3'($urandom);
    check_val("busy_after_start", int'(busy), 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (disturb && cyc == 1) begin
        start = 1'b1; w_we = 1'b1; w_addr = 2'($urandom); w_data = SYN'($urandom);
      end else begin
        start = 1'b0; w_we = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; w_we = 1'b0;
    check_val("done_latency", cyc, 5);
    check_val("busy_in_done", int'(busy), 1);
    check_val("spikes", int'(spikes), int'(m_spikes));
    @(negedge clk);
    check_val("done_one_cycle", int'(done), 0);
    check_val("busy_back_idle", int'(busy), 0);
    check_val("spikes_hold", int'(spikes), int'(m_spikes));
    for (int n = 0; n < NEU; n++) begin
      read_mem(n, v);
      check_val($sformatf("mem_n%0d", n), v, m_mem[n]);
    end
    step_no++;
    $display("step %0d x=%h sh=%0d th=%0d rf=%0d wr=%0b dist=%0b spikes=%b mem=%0d,%0d,%0d,%0d",
             step_no, x, sh, th, rf, wr, disturb, spikes, m_mem[0], m_mem[1], m_mem[2], m_mem[3]);
  endtask

  task automatic expect_mem(input string tag, input int n, input int exp);
    int v;
    read_mem(n, v);
    check_val(tag, v, exp);
  endtask

  initial begin
    int exp_n0 [4];
    int exp_n1 [4];
    int v, seen;
    rst_n = 1'b0; start = 1'b0; inputs = '0; w_we = 1'b0; w_addr = '0; w_data = '0;
    shift = '0; threshold = '0; refractory = '0; mem_rd_addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_done", int'(done), 0);
    check_val("reset_spikes", int'(spikes), 0);
    for (int n = 0; n < NEU; n++) begin
      read_mem(n, v);
      check_val("reset_mem", v, 0);
    end
    rst_n = 1'b1;

    // integrate and fire with clamp at the top of the range
    write_w(0, 8'hFF);
    exp_n0 = '{4, 8, 12, 0};
    for (int s = 0; s < 4; s++) begin
      run_step(8'h0F, 0, 15, 0, 1'b0, 0, '0, 1'b0);
      expect_mem("fire_n0_mem", 0, exp_n0[s]);
      check_val("fire_n0_spike", int'(spikes[0]), (s == 3) ? 1 : 0);
    end

    // negative saturation
    apply_reset();
    write_w(1, 8'h00);
    exp_n1 = '{-8, -16, -16, -16};
    for (int s = 0; s < 3; s++) begin
      run_step(8'hFF, 0, 15, 0, 1'b0, 0, '0, 1'b0);
      expect_mem("negsat_n1_mem", 1, exp_n1[s]);
      check_val("negsat_n1_spike", int'(spikes[1]), 0);
    end

    // leak toward zero from both signs
    apply_reset();
    write_w(0, 8'hFF);
    write_w(1, 8'h00);
    run_step(8'hFF, 0, 15, 0, 1'b0, 0, '0, 1'b0);
    expect_mem("decay_n0_init", 0, 8);
    expect_mem("decay_n1_init", 1, -8);
    exp_n0 = '{4, 2, 1, 1};
    exp_n1 = '{-4, -2, -1, 0};
    for (int s = 0; s < 4; s++) begin
      run_step(8'h00, 1, 15, 0, 1'b0, 0, '0, 1'b0);
      expect_mem("decay_n0", 0, exp_n0[s]);
      expect_mem("decay_n1", 1, exp_n1[s]);
    end

    // refractory hold-off
    apply_reset();
    write_w(0, 8'hFF);
    for (int s = 0; s < 4; s++) begin
      run_step(8'h0F, 0, 4, 2, 1'b0, 0, '0, 1'b0);
      expect_mem("refr_n0_mem", 0, 0);
      check_val("refr_n0_spike", int'(spikes[0]), (s == 0 || s == 3) ? 1 : 0);
    end

    // write in the start cycle is used; start and writes while busy are ignored
    run_step(8'hFF, 0, 3, 0, 1'b1, 2, 8'hFF, 1'b1);
    run_step(8'hA5, 1, 2, 1, 1'b1, 3, 8'h5A, 1'b1);

    // randomised operation
    for (int s = 0; s < 30; s++) begin
      if ($urandom_range(0, 2) == 0) write_w($urandom_range(0, NEU - 1), SYN'($urandom));
      run_step(SYN'($urandom), $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 3),
               bit'($urandom_range(0, 1)), $urandom_range(0, NEU - 1), SYN'($urandom),
               bit'($urandom_range(0, 1)));
    end

    // reset in the middle of a timestep
    for (int n = 0; n < NEU; n++) write_w(n, 8'hFF);
    run_step(8'hFF, 0, 0, 0, 1'b0, 0, '0, 1'b0);
    check_val("pre_abort_spikes", int'(spikes), 15);
    @(negedge clk);
    inputs = 8'hFF; threshold = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_done", int'(done), 0);
    check_val("abort_spikes", int'(spikes), 0);
    for (int n = 0; n < NEU; n++) begin
      read_mem(n, v);
      check_val("abort_mem", v, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check_val("abort_no_done", seen, 0);
    $display("abort: reset mid-timestep, activity after release=%0d", seen);

    // weights were cleared too: with inputs on, every neuron goes negative
    run_step(8'hFF, 0, 15, 0, 1'b0, 0, '0, 1'b0);
    expect_mem("post_abort_n0", 0, -8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/neuron_lif_array.md
NEURON_LIF_ARRAY -- requirements
Module: neuron_lif_array

Interface
REQ-001 Parameter SYNAPSES, default 32: synapse inputs per neuron, power of two, >= 2.
REQ-002 Parameter NEURONS, default 4: neurons time-multiplexed over one datapath, power of two, >= 2; IDX_BITS = $clog2(NEURONS).
REQ-003 Parameter MEMBRANE_BITS, default $clog2(SYNAPSES)+2: signed membrane width.
REQ-004 Parameter THRESHOLD_BITS, default MEMBRANE_BITS-1: unsigned threshold width.
REQ-005 Parameter REFRACTORY_BITS, default 3: refractory counter width.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-007 Port clk, input, 1: rising-edge clock.
REQ-008 Port rst_n, input, 1: asynchronous active-low reset.
REQ-009 Port start, input, 1: begin one timestep.
REQ-010 Port inputs, input, SYNAPSES: binary spike inputs shared by all neurons.
REQ-011 Port w_we / w_addr / w_data, input, 1 / IDX_BITS / SYNAPSES: weight-row write; bit 1 = +1, bit 0 = -1.
REQ-012 Ports shift (3), threshold (THRESHOLD_BITS), refractory (REFRACTORY_BITS), input: global neuron configuration.
REQ-013 Port busy, output, 1: timestep in progress.
REQ-014 Port done, output, 1: one-cycle pulse when a timestep completes.
REQ-015 Port spikes, output, NEURONS: spike vector of the last completed timestep.
REQ-016 Ports mem_rd_addr (input, IDX_BITS) / mem_rd_data (output, signed MEMBRANE_BITS): combinational membrane read.

Function
REQ-017 FSM states: IDLE, EVAL, DONE.
- IDLE + start: latch inputs, shift, threshold, refractory; idx=0; go to EVAL.
- EVAL: process neuron idx per cycle; after idx=NEURONS-1, go to DONE.
- DONE: done=1 for one cycle; spikes updated; go to IDLE.
REQ-018 Latency: start sampled at edge T; done high in the cycle after edge T+NEURONS+1; busy=1 in EVAL and DONE.
REQ-019 start outside IDLE is ignored; inputs changes after latching do not affect the timestep.
REQ-020 psp = sum over synapses of (x_i ? (w_i ? +1 : -1) : 0), range -SYNAPSES..+SYNAPSES.
REQ-021 Decay: shift=0 gives d=u; otherwise d = u - (u >>> shift), arithmetic shift.
REQ-022 acc = d + psp, saturated to [-2^(MEMBRANE_BITS-1), 2^(MEMBRANE_BITS-1)-1]; no wrap-around.
REQ-023 Spike when acc >= zero-extended threshold; membrane becomes acc - threshold (reset by subtraction); refractory counter loaded with refractory.
REQ-024 No spike: membrane becomes acc.
REQ-025 Refractory counter nonzero at evaluation: psp treated as 0, no spike, membrane = d, counter decremented.
REQ-026 Spike bits accumulate in a shadow register; spikes is updated atomically at the EVAL->DONE transition; it holds its value otherwise.
REQ-027 Weight writes take effect only in IDLE, including a write in the same cycle as start, which is used by that timestep; writes while busy are dropped.
REQ-028 mem_rd_data reflects the stored membrane and changes only on the edge that writes it.

Reset
REQ-029 rst_n low, at any time including mid-EVAL, asynchronously forces:
- state IDLE, idx 0, busy 0, done 0, spikes 0;
- all membranes 0, refractory counters 0, weights 0.
REQ-030 A timestep interrupted by reset is abandoned; no done pulse follows.

Verification (SYNAPSES=8, NEURONS=4, MEMBRANE_BITS=5, THRESHOLD_BITS=4)
REQ-031 Integrate/fire: n0 weights 0xFF, inputs 0x0F, shift 0, threshold 15, refractory 0, four timesteps -> n0 membrane 4, 8, 12, then 0 with spikes[0]=1 on step 4 (acc clamped to 15).
REQ-032 Negative saturation: n1 weights 0x00, inputs 0xFF -> membrane -8, -16, -16; no spike.
REQ-033 Decay: membrane 8, inputs 0, shift 1 -> 4, 2, 1, 1. Membrane -8 -> -4, -2, -1, 0.
REQ-034 Refractory: weights 0xFF, inputs 0x0F, threshold 4, refractory 2 -> spikes on steps 1 and 4, membrane 0 on steps 2-3.
REQ-035 Handshake/reset:
- start at edge T -> done pulse after edge T+5; start during busy ignored; w_we during busy leaves weights unchanged.
- rst_n low mid-EVAL -> busy, spikes and membranes 0 at once.
